// File: rtl/alu_exec.sv
// EX-stage execution unit: combinational ALU ops, HI/LO registers, a single-cycle
// multiplier and a 32-step restoring divider that stalls the pipeline while it runs.
module alu_exec #(
  parameter int WIDTH     = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [4:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       sa,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             stall,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [4:0] ALU_AND   = 5'd0;
  localparam logic [4:0] ALU_OR    = 5'd1;
  localparam logic [4:0] ALU_XOR   = 5'd2;
  localparam logic [4:0] ALU_NOR   = 5'd3;
  localparam logic [4:0] ALU_ADD   = 5'd4;
  localparam logic [4:0] ALU_ADDU  = 5'd5;
  localparam logic [4:0] ALU_SUB   = 5'd6;
  localparam logic [4:0] ALU_SUBU  = 5'd7;
  localparam logic [4:0] ALU_SLT   = 5'd8;
  localparam logic [4:0] ALU_SLTU  = 5'd9;
  localparam logic [4:0] ALU_SLL   = 5'd10;
  localparam logic [4:0] ALU_SRL   = 5'd11;
  localparam logic [4:0] ALU_SRA   = 5'd12;
  localparam logic [4:0] ALU_LUI   = 5'd13;
  localparam logic [4:0] ALU_MFHI  = 5'd14;
  localparam logic [4:0] ALU_MFLO  = 5'd15;
  localparam logic [4:0] ALU_MTHI  = 5'd16;
  localparam logic [4:0] ALU_MTLO  = 5'd17;
  localparam logic [4:0] ALU_MULT  = 5'd18;
  localparam logic [4:0] ALU_MULTU = 5'd19;
  localparam logic [4:0] ALU_DIV   = 5'd20;
  localparam logic [4:0] ALU_DIVU  = 5'd21;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} div_state_t;

  div_state_t  state_r, state_nxt_s;
  logic [5:0]  count_r;
  logic [31:0] hi_r, lo_r, rem_r, quot_r, divisor_r;
  logic        neg_q_r, neg_rem_r;

  logic        div_op_s, div_issue_s, op_wr_s, done_wr_s;
  logic        a_neg_s, b_neg_s;
  logic [31:0] a_mag_s, b_mag_s, sum_s, diff_s, q_final_s, r_final_s;
  logic [32:0] shifted_s, trial_s;
  logic [63:0] smul_s, umul_s;

  assign div_op_s    = (alucontrol == ALU_DIV) || (alucontrol == ALU_DIVU);
  assign div_issue_s = (state_r == IDLE) && en && div_op_s && (b != 32'd0) && !flush;
  assign a_neg_s     = (alucontrol == ALU_DIV) && a[31];
  assign b_neg_s     = (alucontrol == ALU_DIV) && b[31];
  assign a_mag_s     = a_neg_s ? (~a + 32'd1) : a;
  assign b_mag_s     = b_neg_s ? (~b + 32'd1) : b;
  assign sum_s       = a + b;
  assign diff_s      = a - b;
  assign smul_s      = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign umul_s      = {32'd0, a} * {32'd0, b};
  // One restoring step: shift in the next dividend bit, keep the difference if non-negative
  assign shifted_s   = {rem_r, quot_r[31]};
  assign trial_s     = shifted_s - {1'b0, divisor_r};
  assign q_final_s   = neg_q_r   ? (~quot_r + 32'd1) : quot_r;
  assign r_final_s   = neg_rem_r ? (~rem_r + 32'd1)  : rem_r;
  assign hi_o        = hi_r;
  assign lo_o        = lo_r;

  // Divider state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Divider next-state logic
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE: begin
        if (div_issue_s) state_nxt_s = RUN;
        else             state_nxt_s = IDLE;
      end
      RUN: begin
        if (flush)                                   state_nxt_s = IDLE;
        else if (count_r == 6'(DIV_ITERS - 1))       state_nxt_s = DONE;
        else                                         state_nxt_s = RUN;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Divider outputs: stall and HI/LO write qualifiers
  always_comb begin
    stall     = 1'b0;
    done_wr_s = 1'b0;
    case (state_r)
      IDLE:    stall = div_issue_s;
      RUN:     stall = 1'b1;
      DONE:    done_wr_s = !flush;
      default: stall = 1'b0;
    endcase
    op_wr_s = en && !flush && !stall;
  end

  // Divider datapath and HI/LO registers; a finishing divide wins over any other write
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      rem_r     <= 32'd0;
      quot_r    <= 32'd0;
      divisor_r <= 32'd0;
      count_r   <= 6'd0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
    end else begin
      if (div_issue_s) begin
        rem_r     <= 32'd0;
        quot_r    <= a_mag_s;
        divisor_r <= b_mag_s;
        count_r   <= 6'd0;
        neg_q_r   <= a_neg_s ^ b_neg_s;
        neg_rem_r <= a_neg_s;
      end else if (state_r == RUN) begin
        rem_r   <= trial_s[32] ? shifted_s[31:0] : trial_s[31:0];
        quot_r  <= {quot_r[30:0], !trial_s[32]};
        count_r <= count_r + 6'd1;
      end else begin
        rem_r   <= rem_r;
        quot_r  <= quot_r;
      end
      if (done_wr_s) begin
        hi_r <= r_final_s;
        lo_r <= q_final_s;
      end else if (op_wr_s) begin
        case (alucontrol)
          ALU_MTHI:  hi_r <= a;
          ALU_MTLO:  lo_r <= a;
          ALU_MULT:  {hi_r, lo_r} <= smul_s;
          ALU_MULTU: {hi_r, lo_r} <= umul_s;
          default: begin
            hi_r <= hi_r;
            lo_r <= lo_r;
          end
        endcase
      end else begin
        hi_r <= hi_r;
        lo_r <= lo_r;
      end
    end
  end

  // Combinational result and signed-overflow detection
  always_comb begin
    result   = 32'd0;
    overflow = 1'b0;
    if (en) begin
      case (alucontrol)
        ALU_AND:  result = a & b;
        ALU_OR:   result = a | b;
        ALU_XOR:  result = a ^ b;
        ALU_NOR:  result = ~(a | b);
        ALU_ADD: begin
          result   = sum_s;
          overflow = (a[31] == b[31]) && (sum_s[31] != a[31]);
        end
        ALU_ADDU: result = sum_s;
        ALU_SUB: begin
          result   = diff_s;
          overflow = (a[31] != b[31]) && (diff_s[31] != a[31]);
        end
        ALU_SUBU: result = diff_s;
        ALU_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
        ALU_SLTU: result = {31'd0, (a < b)};
        ALU_SLL:  result = b << sa;
        ALU_SRL:  result = b >> sa;
        ALU_SRA:  result = $signed(b) >>> sa;
        ALU_LUI:  result = {b[15:0], 16'h0000};
        ALU_MFHI: result = hi_r;
        ALU_MFLO: result = lo_r;
        default:  result = 32'd0;
      endcase
    end else begin
      result   = 32'd0;
      overflow = 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Randomized self-checking bench for alu_exec against an arithmetic reference model.
module tb_alu_exec;

  localparam logic [4:0] C_AND = 5'd0,  C_OR = 5'd1,   C_XOR = 5'd2,  C_NOR = 5'd3;
  localparam logic [4:0] C_ADD = 5'd4,  C_ADDU = 5'd5, C_SUB = 5'd6,  C_SUBU = 5'd7;
  localparam logic [4:0] C_SLT = 5'd8,  C_SLTU = 5'd9, C_SLL = 5'd10, C_SRL = 5'd11;
  localparam logic [4:0] C_SRA = 5'd12, C_LUI = 5'd13, C_MFHI = 5'd14, C_MFLO = 5'd15;
  localparam logic [4:0] C_MTHI = 5'd16, C_MTLO = 5'd17, C_MULT = 5'd18, C_MULTU = 5'd19;
  localparam logic [4:0] C_DIV = 5'd20, C_DIVU = 5'd21;

  logic        clk = 1'b0;
  logic        rst, en, flush;
  logic [4:0]  alucontrol, sa;
  logic [31:0] a, b, result, hi_o, lo_o;
  logic        overflow, stall;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  alu_exec #(.WIDTH(32), .DIV_ITERS(32)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .alucontrol(alucontrol),
    .a(a), .b(b), .sa(sa), .result(result), .overflow(overflow), .stall(stall),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_result(input logic [4:0] c, input logic [31:0] x,
                                             input logic [31:0] y, input logic [4:0] s);
    longint sx, sy, v;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (c)
      C_AND:  return x & y;
      C_OR:   return x | y;
      C_XOR:  return x ^ y;
      C_NOR:  return ~(x | y);
      C_ADD, C_ADDU: begin v = sx + sy; return v[31:0]; end
      C_SUB, C_SUBU: begin v = sx - sy; return v[31:0]; end
      C_SLT:  return (sx < sy) ? 32'd1 : 32'd0;
      C_SLTU: return ({32'd0, x} < {32'd0, y}) ? 32'd1 : 32'd0;
      C_SLL:  return y << s;
      C_SRL:  return y >> s;
      C_SRA:  begin v = sy >>> s; return v[31:0]; end
      C_LUI:  return y * 32'd65536;
      C_MFHI: return hi_m;
      C_MFLO: return lo_m;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y);
    longint v;
    if (c == C_ADD)      v = longint'($signed(x)) + longint'($signed(y));
    else if (c == C_SUB) v = longint'($signed(x)) - longint'($signed(y));
    else                 return 1'b0;
    return (v > 64'sd2147483647) || (v < -64'sd2147483648);
  endfunction

  task automatic drive(input logic e, input logic [4:0] c, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] s, input logic f);
    en = e; alucontrol = c; a = x; b = y; sa = s; flush = f;
  endtask

  task automatic test_reset();
    drive(1'b1, C_MTHI, 32'hDEAD_BEEF, 32'd0, 5'd0, 1'b0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    drive(1'b0, C_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0);
    @(negedge clk);
    vectors++;
    if (hi_o !== 32'd0 || lo_o !== 32'd0 || stall !== 1'b0 || result !== 32'd0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: hi=%h lo=%h stall=%b result=%h ovf=%b, required all zero", hi_o, lo_o, stall, result, overflow);
    end
    tick();
  endtask

  task automatic test_directed();
    logic [4:0]  cs [6] = '{C_ADD, C_ADDU, C_SRA, C_SLTU, C_SLT, C_LUI};
    logic [31:0] as [6] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd1, 32'd1, 32'd0};
    logic [31:0] bs [6] = '{32'd1, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1234};
    logic [31:0] rs [6] = '{32'h8000_0000, 32'h8000_0000, 32'hF800_0000, 32'd1, 32'd0, 32'h1234_0000};
    logic        os [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, cs[i], as[i], bs[i], 5'd4, 1'b0);
      @(negedge clk);
      vectors++;
      if (result !== rs[i] || overflow !== os[i]) begin
        miscompares++;
        $display("FAIL directed[%0d]: result=%h ovf=%b, required %h ovf=%b", i, result, overflow, rs[i], os[i]);
      end
      tick();
    end
  endtask

  task automatic test_comb_random();
    logic [4:0]  c, s;
    logic [31:0] x, y;
    logic        e;
    for (int i = 0; i < 60; i++) begin
      c = 5'($urandom_range(0, 31));
      if (c >= C_MTHI && c <= C_DIVU) c = c - 5'd16;
      x = $urandom; y = $urandom; s = 5'($urandom_range(0, 31));
      if (i % 7 == 3) begin x = 32'h8000_0000; y = (c == C_ADD) ? 32'h8000_0000 : 32'h0000_0001; end
      e = (i % 10 != 9);
      drive(e, c, x, y, s, 1'b0);
      @(negedge clk);
      vectors++;
      if (result !== (e ? ref_result(c, x, y, s) : 32'd0) || overflow !== (e & ref_ovf(c, x, y))) begin
        miscompares++;
        $display("FAIL comb op=%0d en=%b a=%h b=%h sa=%0d: result=%h ovf=%b, required %h ovf=%b",
                 c, e, x, y, s, result, overflow, e ? ref_result(c, x, y, s) : 32'd0, e & ref_ovf(c, x, y));
      end
      tick();
    end
  endtask

  task automatic test_mult_mt();
    logic [4:0]  c;
    logic [31:0] x, y;
    longint      p;
    logic [63:0] up;
    for (int i = 0; i < 10; i++) begin
      c = (i % 2 == 0) ? C_MULT : C_MULTU;
      x = (i == 0) ? 32'hFFFF_FFFE : $urandom;
      y = (i == 0) ? 32'd3 : $urandom;
      if (i == 8) c = C_MTHI;
      if (i == 9) c = C_MTLO;
      drive(1'b1, c, x, y, 5'd0, 1'b0);
      @(negedge clk);
      vectors++;
      if (stall !== 1'b0 || result !== 32'd0) begin
        miscompares++;
        $display("FAIL mult_issue op=%0d: stall=%b result=%h, required 0 and 0", c, stall, result);
      end
      tick();
      if (c == C_MULT) begin
        p = longint'($signed(x)) * longint'($signed(y));
        hi_m = p[63:32]; lo_m = p[31:0];
      end else if (c == C_MULTU) begin
        up = {32'd0, x} * {32'd0, y};
        hi_m = up[63:32]; lo_m = up[31:0];
      end else if (c == C_MTHI) hi_m = x;
      else lo_m = x;
      drive(1'b1, (i % 3 == 0) ? C_MFHI : C_MFLO, 32'd0, 32'd0, 5'd0, 1'b0);
      @(negedge clk);
      vectors++;
      if (hi_o !== hi_m || lo_o !== lo_m || result !== ((i % 3 == 0) ? hi_m : lo_m)) begin
        miscompares++;
        $display("FAIL mult/mt[%0d] op=%0d: hi=%h lo=%h mf=%h, required hi=%h lo=%h", i, c, hi_o, lo_o, result, hi_m, lo_m);
      end
      tick();
    end
    drive(1'b1, C_MTHI, 32'h1111_2222, 32'd0, 5'd0, 1'b1);
    tick();
    drive(1'b0, C_AND, 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    vectors++;
    if (hi_o !== hi_m) begin
      miscompares++;
      $display("FAIL mthi_flush: hi=%h, required %h", hi_o, hi_m);
    end
    tick();
  endtask

  task automatic do_div(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    longint sq, sr;
    drive(1'b1, c, x, y, 5'd0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stall !== 1'b1) break;
      n++;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (n != 33) begin
      miscompares++;
      $display("FAIL div_stall op=%0d a=%h b=%h: stall cycles=%0d, required 33", c, x, y, n);
    end
    tick();
    drive(1'b0, C_AND, 32'd0, 32'd0, 5'd0, 1'b0);
    if (c == C_DIVU) begin
      lo_m = x / y; hi_m = x % y;
    end else begin
      sq = longint'($signed(x)) / longint'($signed(y));
      sr = longint'($signed(x)) % longint'($signed(y));
      lo_m = sq[31:0]; hi_m = sr[31:0];
    end
    @(negedge clk);
    vectors++;
    if (hi_o !== hi_m || lo_o !== lo_m || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL div op=%0d a=%h b=%h: hi=%h lo=%h stall=%b, required hi=%h lo=%h", c, x, y, hi_o, lo_o, stall, hi_m, lo_m);
    end
    tick();
  endtask

  task automatic test_divide();
    do_div(C_DIV,  32'hFFFF_FFF9, 32'd2);
    do_div(C_DIVU, 32'd100,       32'd7);
    do_div(C_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      do_div((i % 2 == 0) ? C_DIV : C_DIVU, $urandom, $urandom_range(1, 32'hFFFF_FFFF) >> (i * 7));
    end
  endtask

  task automatic test_div_zero();
    drive(1'b1, C_DIVU, 32'd55, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL divzero_stall: stall=%b, required 0", stall);
    end
    tick();
    drive(1'b0, C_AND, 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0 || hi_o !== hi_m || lo_o !== lo_m) begin
      miscompares++;
      $display("FAIL divzero: stall=%b hi=%h lo=%h, required 0 hi=%h lo=%h", stall, hi_o, lo_o, hi_m, lo_m);
    end
    tick();
  endtask

  task automatic test_div_flush();
    drive(1'b1, C_DIV, 32'hFFFF_FF9C, 32'd3, 5'd0, 1'b0);
    tick();
    repeat (10) tick();
    flush = 1'b1;
    tick();
    drive(1'b0, C_AND, 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0 || hi_o !== hi_m || lo_o !== lo_m) begin
      miscompares++;
      $display("FAIL div_flush: stall=%b hi=%h lo=%h, required 0 hi=%h lo=%h", stall, hi_o, lo_o, hi_m, lo_m);
    end
    tick();
    do_div(C_DIV, 32'hFFFF_FF9C, 32'd3);
  endtask

  task automatic test_reset_mid_div();
    drive(1'b1, C_DIVU, 32'd1000, 32'd9, 5'd0, 1'b0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, C_AND, 32'd0, 32'd0, 5'd0, 1'b0);
    hi_m = 32'd0; lo_m = 32'd0;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_mid_div: stall=%b hi=%h lo=%h, required all zero", stall, hi_o, lo_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_div(C_DIVU, 32'd12345, 32'd10);
    drive(1'b1, C_MULTU, 32'h0001_0000, 32'h0001_0000, 5'd0, 1'b0);
    tick();
    hi_m = 32'd1; lo_m = 32'd0;
    drive(1'b1, C_MFHI, 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    vectors++;
    if (result !== 32'd1 || lo_o !== 32'd0) begin
      miscompares++;
      $display("FAIL b2b_mfhi: result=%h lo=%h, required 1 and 0", result, lo_o);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, C_AND, 32'd0, 32'd0, 5'd0, 1'b0);
    test_reset();
    test_directed();
    test_comb_random();
    test_mult_mt();
    test_divide();
    test_div_zero();
    test_div_flush();
    test_reset_mid_div();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
